// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   - fetch_state_e : request FSM states (idle, waiting on memory, dropping a stale response)
//   - INST_W        : stored instruction width
//   - OPC_FULL      : low opcode bits that mark a full 32-bit instruction
//   - inst_is_rvc() : sizes a fetched instruction from its two low bits
package inst_fetch_queue_pkg;

    localparam int INST_W = 32;
    localparam logic [1:0] OPC_FULL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    function automatic logic inst_is_rvc(input logic [1:0] low, input bit enable);
        return enable && (low != OPC_FULL);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle around the fetch queue.
//   master : the fetch queue itself (drives memory request and dequeue side)
//   slave  : its environment (ROB, decoder, memory controller)
// Signals: flush/redirect/hold from ROB and decoder, memory request/response,
// FIFO head (valid/inst/pc/rvc/ready) and occupancy count.
interface inst_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic            clear;
    logic [XLEN-1:0] rob_new_pc;
    logic            dec_redirect;
    logic [XLEN-1:0] dec_target;
    logic            dec_hold;
    logic            mem_busy;
    logic            mem_ready;
    logic [31:0]     mem_data;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            deq_valid;
    logic [31:0]     deq_inst;
    logic [XLEN-1:0] deq_pc;
    logic            deq_rvc;
    logic            deq_ready;
    logic [CNT_W-1:0] count;

    modport master (
        input  clear, rob_new_pc, dec_redirect, dec_target, dec_hold,
               mem_busy, mem_ready, mem_data, deq_ready,
        output mem_req, mem_addr, deq_valid, deq_inst, deq_pc, deq_rvc, count
    );

    modport slave (
        output clear, rob_new_pc, dec_redirect, dec_target, dec_hold,
               mem_busy, mem_ready, mem_data, deq_ready,
        input  mem_req, mem_addr, deq_valid, deq_inst, deq_pc, deq_rvc, count
    );

endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous FIFO with flush, used as the fetched-instruction queue.
// Ports: clk, rst (async active-high), en (low freezes all state), flush (empties),
//        enq/enq_data, deq (pop head when non-empty), deq_valid/deq_data (head), count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module inst_fetch_queue_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     enq,
    input  logic [WIDTH-1:0]         enq_data,
    input  logic                     deq,
    output logic                     deq_valid,
    output logic [WIDTH-1:0]         deq_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             do_enq;
    logic             do_deq;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_enq    = en && enq && !flush;
    assign do_deq    = en && deq && !empty && !flush;
    assign deq_valid = !empty;
    assign deq_data  = mem[rd_ptr[AW-1:0]];
    assign count     = wr_ptr - rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (en) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_enq) wr_ptr <= wr_ptr + 1'b1;
                if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; an entry is only visible once written, so
    // clearing the array would cost logic without changing behaviour.
    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr[AW-1:0]] <= enq_data;
    end

    // The request rule keeps a slot free for every outstanding fetch.
    a_no_enq_on_full: assert property (@(posedge clk) disable iff (rst) !(do_enq && full));

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: owns the PC, issues word fetches, sizes each returned
// instruction (16-bit RVC or 32-bit) and queues {inst, pc, rvc} for the decoder.
// Ports: clk_in, rst_in (async active-high), rdy_in (low freezes everything),
//        bus (master side of inst_fetch_queue_if: flush/redirect/hold inputs,
//        memory request/response, FIFO head and occupancy).
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 8,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter bit              ENABLE_RVC = 1'b1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    inst_fetch_queue_if.master   bus
);
    // Entry layout lives here rather than in the package because its PC
    // field follows this instance's XLEN.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
        logic              rvc;
    } entry_t;

    fetch_state_e      state;
    logic [XLEN-1:0]   pc;
    logic              flush;
    logic              resp_rvc;
    logic [INST_W-1:0] resp_inst;
    logic              enq;
    logic              in_flight;
    logic              req_ok;
    entry_t            enq_entry;
    entry_t            head;

    assign flush     = bus.clear || bus.dec_redirect;
    assign resp_rvc  = inst_is_rvc(bus.mem_data[1:0], ENABLE_RVC);
    assign resp_inst = resp_rvc ? {16'b0, bus.mem_data[15:0]} : bus.mem_data;

    // A response that coincides with a flush belongs to the old path and is dropped.
    assign enq       = (state == S_WAIT) && bus.mem_ready && !flush;
    assign in_flight = (state == S_WAIT);
    assign req_ok    = (state == S_IDLE) && !bus.mem_busy && !bus.dec_hold && !flush
                       && ((32'(bus.count) + 32'(in_flight)) < DEPTH);

    assign enq_entry = '{inst: resp_inst, pc: pc, rvc: resp_rvc};

    inst_fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .en        (rdy_in),
        .flush     (flush),
        .enq       (enq),
        .enq_data  (enq_entry),
        .deq       (bus.deq_valid && bus.deq_ready),
        .deq_valid (bus.deq_valid),
        .deq_data  (head),
        .count     (bus.count)
    );

    assign bus.deq_inst = head.inst;
    assign bus.deq_pc   = head.pc;
    assign bus.deq_rvc  = head.rvc;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
        end else if (rdy_in) begin
            bus.mem_req <= 1'b0;

            // ROB flush outranks decoder redirect, which outranks sequential advance.
            if (bus.clear)             pc <= bus.rob_new_pc;
            else if (bus.dec_redirect) pc <= bus.dec_target;
            else if (enq)              pc <= pc + (resp_rvc ? XLEN'(2) : XLEN'(4));

            case (state)
                S_IDLE: begin
                    if (req_ok) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= pc;
                        state        <= S_WAIT;
                    end
                end
                // A response arriving with the flush retires the request; only
                // a flush with the response still pending needs DROP.
                S_WAIT: begin
                    if (bus.mem_ready) state <= S_IDLE;
                    else if (flush)    state <= S_DROP;
                end
                S_DROP: begin
                    if (bus.mem_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (DEPTH=4, RESET_PC=0, RVC enabled).
// Stimulus pushes expected memory requests and dequeued entries into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_inst_fetch_queue;

    logic clk;
    logic rst;
    logic rdy;

    inst_fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

    inst_fetch_queue #(
        .XLEN       (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0),
        .ENABLE_RVC (1'b1)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        rvc;
    } exp_t;

    exp_t        exp_deq [$];
    logic [31:0] exp_req [$];
    int          checks   = 0;
    int          errors   = 0;
    int          req_seen = 0;

    logic [7:0]  mem [1024];
    logic        auto_mem;
    logic        auto_ready;
    logic [31:0] auto_data;
    logic        man_ready;
    logic [31:0] man_data;

    assign bus.mem_ready = auto_ready | man_ready;
    assign bus.mem_data  = auto_ready ? auto_data : man_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [9:0] b;
        b = a[9:0];
        return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] d);
        logic [9:0] b;
        b = a[9:0];
        mem[b]         = d[7:0];
        mem[b + 10'd1] = d[15:8];
        mem[b + 10'd2] = d[23:16];
        mem[b + 10'd3] = d[31:24];
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_deq(input logic [31:0] inst, input logic [31:0] pc, input logic rvc);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.rvc  = rvc;
        exp_deq.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int target);
        int budget;
        budget = 0;
        while (req_seen < target && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (req_seen < target) begin
            checks++;
            errors++;
            $display("FAIL req_timeout seen=%0d want=%0d", req_seen, target);
        end
    endtask

    // Let exactly n requests through, then hold and let the last one finish.
    task automatic fetch_n(input int n);
        int target;
        target = req_seen + n;
        bus.dec_hold = 1'b0;
        wait_req(target);
        tick();
        bus.dec_hold = 1'b1;
        tick(4);
    endtask

    task automatic pulse_clear(input logic [31:0] new_pc);
        bus.rob_new_pc = new_pc;
        bus.clear      = 1'b1;
        tick();
        bus.clear      = 1'b0;
    endtask

    // Auto memory: one-cycle response one cycle after the request is seen.
    initial begin
        logic [31:0] a;
        auto_ready = 1'b0;
        auto_data  = '0;
        forever begin
            @(negedge clk);
            if (auto_mem && !rst && rdy && bus.mem_req) begin
                a = bus.mem_addr;
                @(posedge clk);
                #1;
                auto_data  = mem_word(a);
                auto_ready = 1'b1;
                @(posedge clk);
                #1;
                auto_ready = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rdy && bus.mem_req) begin
            req_seen++;
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req addr=%h", bus.mem_addr);
            end else begin
                check("req_addr", 64'(bus.mem_addr), 64'(exp_req.pop_front()));
            end
        end
        if (!rst && rdy && bus.deq_valid && bus.deq_ready) begin
            if (exp_deq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_deq pc=%h inst=%h", bus.deq_pc, bus.deq_inst);
            end else begin
                e = exp_deq.pop_front();
                check("deq_inst", 64'(bus.deq_inst), 64'(e.inst));
                check("deq_pc",   64'(bus.deq_pc),   64'(e.pc));
                check("deq_rvc",  64'(bus.deq_rvc),  64'(e.rvc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench watchdog");
    end

    initial begin
        int start;
        rst = 1'b1;
        rdy = 1'b1;
        bus.clear        = 1'b0;
        bus.rob_new_pc   = '0;
        bus.dec_redirect = 1'b0;
        bus.dec_target   = '0;
        bus.dec_hold     = 1'b1;
        bus.mem_busy     = 1'b0;
        bus.deq_ready    = 1'b0;
        man_ready = 1'b0;
        man_data  = '0;
        auto_mem  = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = (i % 4 == 0) ? 8'h13 : 8'h00;

        // Reset state
        tick(2);
        check("rst_mem_req",   64'(bus.mem_req),   64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        check("rst_count",     64'(bus.count),     64'd0);
        rst = 1'b0;
        tick();

        // T1: sequential 32-bit fetches from reset PC
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        push_deq(32'h13, 32'h0, 1'b0);
        push_deq(32'h13, 32'h4, 1'b0);
        bus.deq_ready = 1'b1;
        fetch_n(2);
        check("t1_count", 64'(bus.count), 64'd0);

        // T2: two RVC halves then a 32-bit instruction
        set_word(32'h0, 32'h4505_4501);
        pulse_clear(32'h0);
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h2);
        exp_req.push_back(32'h4);
        push_deq(32'h4501, 32'h0, 1'b1);
        push_deq(32'h4505, 32'h2, 1'b1);
        push_deq(32'h13,   32'h4, 1'b0);
        fetch_n(3);
        check("t2_count", 64'(bus.count), 64'd0);

        // T3: fill to DEPTH with consumer stalled, then one slot frees one request
        bus.deq_ready = 1'b0;
        pulse_clear(32'h10);
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back(32'h10 + 32'(4 * i));
            push_deq(32'h13, 32'h10 + 32'(4 * i), 1'b0);
        end
        start = req_seen;
        bus.dec_hold = 1'b0;
        tick(30);
        check("t3_req_total", 64'(req_seen - start), 64'd4);
        check("t3_count_full", 64'(bus.count), 64'd4);
        check("t3_no_req", 64'(bus.mem_req), 64'd0);
        exp_req.push_back(32'h20);
        push_deq(32'h13, 32'h20, 1'b0);
        bus.deq_ready = 1'b1;
        tick();
        bus.deq_ready = 1'b0;
        wait_req(start + 5);
        tick();
        bus.dec_hold = 1'b1;
        tick(4);
        check("t3_refill", 64'(bus.count), 64'd4);
        bus.deq_ready = 1'b1;
        tick(6);
        check("t3_drained", 64'(bus.count), 64'd0);

        // T4: ROB clear while a fetch is outstanding
        auto_mem = 1'b0;
        exp_req.push_back(32'h24);
        start = req_seen;
        bus.dec_hold = 1'b0;
        wait_req(start + 1);
        tick();
        bus.dec_hold = 1'b1;
        tick(2);
        bus.rob_new_pc = 32'h100;
        bus.clear      = 1'b1;
        tick();
        bus.clear    = 1'b0;
        bus.dec_hold = 1'b0;
        start = req_seen;
        tick(4);
        check("t4_drop_no_req", 64'(req_seen - start), 64'd0);
        man_data  = 32'h0000_0013;
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        auto_mem  = 1'b1;
        check("t4_stale_count", 64'(bus.count), 64'd0);
        exp_req.push_back(32'h100);
        push_deq(32'h13, 32'h100, 1'b0);
        wait_req(start + 1);
        tick();
        bus.dec_hold = 1'b1;
        tick(4);

        // T5: decoder redirect coinciding with response and dequeue
        bus.deq_ready = 1'b0;
        exp_req.push_back(32'h104);
        push_deq(32'h13, 32'h104, 1'b0);
        fetch_n(1);
        check("t5_count_pre", 64'(bus.count), 64'd1);
        auto_mem = 1'b0;
        exp_req.push_back(32'h108);
        start = req_seen;
        bus.dec_hold = 1'b0;
        wait_req(start + 1);
        tick();
        bus.dec_hold = 1'b1;
        tick();
        bus.dec_redirect = 1'b1;
        bus.dec_target   = 32'h40;
        man_data         = 32'h0000_0013;
        man_ready        = 1'b1;
        bus.deq_ready    = 1'b1;
        tick();
        bus.dec_redirect = 1'b0;
        man_ready        = 1'b0;
        check("t5_count_post", 64'(bus.count), 64'd0);
        check("t5_valid_post", 64'(bus.deq_valid), 64'd0);
        auto_mem = 1'b1;
        exp_req.push_back(32'h40);
        push_deq(32'h13, 32'h40, 1'b0);
        fetch_n(1);

        // T6: hold blocks requests; release requests next cycle; rdy low freezes
        start = req_seen;
        tick(10);
        check("t6_hold_no_req", 64'(req_seen - start), 64'd0);
        bus.deq_ready = 1'b0;
        exp_req.push_back(32'h44);
        push_deq(32'h13, 32'h44, 1'b0);
        bus.dec_hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_req_next_cycle", 64'(bus.mem_req), 64'd1);
        tick();
        bus.dec_hold = 1'b1;
        tick(4);
        check("t6_count_one", 64'(bus.count), 64'd1);
        rdy = 1'b0;
        bus.dec_hold  = 1'b0;
        bus.deq_ready = 1'b1;
        start = req_seen;
        tick(5);
        check("t6_frozen_count", 64'(bus.count), 64'd1);
        check("t6_frozen_valid", 64'(bus.deq_valid), 64'd1);
        check("t6_frozen_no_req", 64'(req_seen - start), 64'd0);
        bus.dec_hold = 1'b1;
        rdy = 1'b1;
        tick(3);
        check("t6_count_after", 64'(bus.count), 64'd0);
        exp_req.push_back(32'h48);
        push_deq(32'h13, 32'h48, 1'b0);
        fetch_n(1);

        // T7: PC wrap-around at the top of the address space
        pulse_clear(32'hFFFF_FFFC);
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0);
        push_deq(32'h13,   32'hFFFF_FFFC, 1'b0);
        push_deq(32'h4501, 32'h0,         1'b1);
        fetch_n(2);

        // T8: busy memory controller blocks requests
        bus.mem_busy = 1'b1;
        bus.dec_hold = 1'b0;
        start = req_seen;
        tick(5);
        check("t8_busy_no_req", 64'(req_seen - start), 64'd0);
        exp_req.push_back(32'h2);
        push_deq(32'h4505, 32'h2, 1'b1);
        bus.mem_busy = 1'b0;
        fetch_n(1);

        tick(5);
        check("left_req", 64'(exp_req.size()), 64'd0);
        check("left_deq", 64'(exp_deq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
